// File: rtl/tdc_pkg.sv
// Shared TDC definitions: default tap count, fine-time type, encode-mode
// constants and the majority helper used by the optional bubble filter.
package tdc_pkg;

   localparam int TDC_NUM_TAPS = 32;
   localparam int TDC_OUT_W    = $clog2(TDC_NUM_TAPS + 1);

   typedef logic [TDC_OUT_W-1:0] tdc_fine_t;

   localparam logic ENC_LAST_ONE = 1'b0;
   localparam logic ENC_POPCOUNT = 1'b1;

   // Three-input majority vote; removes an isolated flipped tap.
   function automatic logic tdc_maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/tdc_thermo_group_enc.sv
// One thermometer group: popcount, index of the highest set tap, and an
// any-set flag. Purely combinational; the caller registers the results.
module tdc_thermo_group_enc #(
   parameter  int GROUP_W = 8,
   localparam int PC_W    = $clog2(GROUP_W + 1),
   localparam int HI_W    = $clog2(GROUP_W)
) (
   input  logic [GROUP_W-1:0] grp_bits,
   output logic [PC_W-1:0]    popcnt,
   output logic [HI_W-1:0]    hi,
   output logic               any
);

   // Scan taps low to high: count ones, keep the last (highest) set index.
   always_comb begin
      popcnt = '0;
      hi     = '0;
      any    = 1'b0;
      for (int i = 0; i < GROUP_W; i++) begin
         popcnt = popcnt + PC_W'(grp_bits[i]);
         if (grp_bits[i]) begin
            hi  = HI_W'(i);
            any = 1'b1;
         end else begin
            hi  = hi;
         end
      end
   end

endmodule

// File: rtl/tdc_thermo_encoder_pipe.sv
// Three-stage thermometer-to-binary encoder for the TDC fine-time path.
// S1 captures the code (optionally majority-filtered) and the mode, S2 holds
// per-group popcount / highest index, S3 reduces to the encoded value and
// flags. A saturating counter tallies bubbled samples.
// Optional feature: define TDC_BUBBLE_FILTER_EN to majority-filter the code in S1.
module tdc_thermo_encoder_pipe
   import tdc_pkg::*;
#(
   parameter  int NUM_TAPS = TDC_NUM_TAPS,
   parameter  int GROUP_W  = 8,
   parameter  int CNT_W    = 16,
   localparam int OUT_W    = $clog2(NUM_TAPS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_TAPS-1:0] thermo,
   input  logic                in_valid,
   input  logic                mode,
   input  logic                cnt_clr,
   output logic [OUT_W-1:0]    binary,
   output logic                out_valid,
   output logic                bubble,
   output logic                all_ones,
   output logic                all_zeros,
   output logic [CNT_W-1:0]    bubble_cnt
);

   localparam int NUM_GROUPS = NUM_TAPS / GROUP_W;
   localparam int PC_W       = $clog2(GROUP_W + 1);
   localparam int HI_W       = $clog2(GROUP_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [NUM_TAPS-1:0] s1_data_s;
   logic [NUM_TAPS-1:0] th1_r;
   logic                mode1_r;
   logic                v1_r;

   logic [PC_W-1:0]     gpc_s  [NUM_GROUPS];
   logic [HI_W-1:0]     ghi_s  [NUM_GROUPS];
   logic                gany_s [NUM_GROUPS];
   logic [PC_W-1:0]     pc2_r  [NUM_GROUPS];
   logic [HI_W-1:0]     hi2_r  [NUM_GROUPS];
   logic                any2_r [NUM_GROUPS];
   logic                mode2_r;
   logic                v2_r;

   logic [OUT_W-1:0]    pop_s;
   logic [OUT_W-1:0]    last_s;
   logic [OUT_W-1:0]    bin_s;

`ifdef TDC_BUBBLE_FILTER_EN
   logic [NUM_TAPS+1:0] ext_s;

   // Majority filter with a virtual 1 below tap 0 and a virtual 0 above the last tap.
   always_comb begin
      ext_s     = {1'b0, thermo, 1'b1};
      s1_data_s = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         s1_data_s[i] = tdc_maj3(ext_s[i], ext_s[i+1], ext_s[i+2]);
      end
   end
`else
   // Unfiltered path: the captured code goes straight into S1.
   always_comb begin
      s1_data_s = thermo;
   end
`endif

   // S1: capture the code and its encode mode when a sample arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r    <= 1'b0;
         th1_r   <= '0;
         mode1_r <= ENC_LAST_ONE;
      end else begin
         v1_r <= in_valid;
         if (in_valid) begin
            th1_r   <= s1_data_s;
            mode1_r <= mode;
         end
      end
   end

   for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
      tdc_thermo_group_enc #(.GROUP_W(GROUP_W)) u_enc (
         .grp_bits (th1_r[g*GROUP_W +: GROUP_W]),
         .popcnt   (gpc_s[g]),
         .hi       (ghi_s[g]),
         .any      (gany_s[g])
      );
   end

   // S2: register per-group partial results alongside the sample's mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r    <= 1'b0;
         mode2_r <= ENC_LAST_ONE;
         for (int g = 0; g < NUM_GROUPS; g++) begin
            pc2_r[g]  <= '0;
            hi2_r[g]  <= '0;
            any2_r[g] <= 1'b0;
         end
      end else begin
         v2_r <= v1_r;
         if (v1_r) begin
            mode2_r <= mode1_r;
            for (int g = 0; g < NUM_GROUPS; g++) begin
               pc2_r[g]  <= gpc_s[g];
               hi2_r[g]  <= ghi_s[g];
               any2_r[g] <= gany_s[g];
            end
         end
      end
   end

   // S3 reduction: total popcount and position just past the highest set tap.
   always_comb begin
      pop_s  = '0;
      last_s = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         pop_s = pop_s + OUT_W'(pc2_r[g]);
         if (any2_r[g]) begin
            last_s = OUT_W'(g * GROUP_W) + OUT_W'(hi2_r[g]) + OUT_W'(1);
         end else begin
            last_s = last_s;
         end
      end
      bin_s = (mode2_r == ENC_POPCOUNT) ? pop_s : last_s;
   end

   // S3: register the encoded value and flags; held while no sample is present.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         binary    <= '0;
         bubble    <= 1'b0;
         all_ones  <= 1'b0;
         all_zeros <= 1'b0;
      end else begin
         out_valid <= v2_r;
         if (v2_r) begin
            binary    <= bin_s;
            bubble    <= (pop_s != last_s);
            all_ones  <= (bin_s == OUT_W'(NUM_TAPS));
            all_zeros <= (bin_s == OUT_W'(0));
         end
      end
   end

   // Saturating bubble tally; a clear in the same cycle as a bubble wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt <= '0;
      end else if (cnt_clr) begin
         bubble_cnt <= '0;
      end else if (out_valid && bubble && (bubble_cnt != CNT_MAX)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tdc_thermo_encoder_pipe.sv
// Directed self-checking bench for tdc_thermo_encoder_pipe (32 taps, 8-tap groups).
// Expected values for bubbled codes depend on whether TDC_BUBBLE_FILTER_EN is defined.
module tb_tdc_thermo_encoder_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] thermo;
   logic        in_valid;
   logic        mode;
   logic        cnt_clr;
   logic [5:0]  binary;
   logic        out_valid;
   logic        bubble;
   logic        all_ones;
   logic        all_zeros;
   logic [15:0] bubble_cnt;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   logic [15:0] exp_cnt   = 16'd0;

`ifdef TDC_BUBBLE_FILTER_EN
   localparam logic [5:0] EXP_F7_M0  = 6'd8;
   localparam logic [5:0] EXP_F7_M1  = 6'd8;
   localparam logic       EXP_F7_BUB = 1'b0;
`else
   localparam logic [5:0] EXP_F7_M0  = 6'd8;
   localparam logic [5:0] EXP_F7_M1  = 6'd7;
   localparam logic       EXP_F7_BUB = 1'b1;
`endif

   always #5 clk = ~clk;

   tdc_thermo_encoder_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .thermo     (thermo),
      .in_valid   (in_valid),
      .mode       (mode),
      .cnt_clr    (cnt_clr),
      .binary     (binary),
      .out_valid  (out_valid),
      .bubble     (bubble),
      .all_ones   (all_ones),
      .all_zeros  (all_zeros),
      .bubble_cnt (bubble_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] t, input logic v, input logic m);
      thermo   = t;
      in_valid = v;
      mode     = m;
   endtask

   // One sample, then idle until its result is on the outputs.
   task automatic send(input logic [31:0] t, input logic m);
      drive(t, 1'b1, m);
      step();
      in_valid = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cnt_clr = 1'b0;
      drive(32'hFFFF_FFFF, 1'b1, 1'b1);
      step(); step(); step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (binary !== 6'd0) $display("FAIL reset_binary: got %0d want 0", binary); else pass_cnt++;
      total_cnt++; if (bubble !== 1'b0) $display("FAIL reset_bubble: got %b want 0", bubble); else pass_cnt++;
      total_cnt++; if (all_ones !== 1'b0) $display("FAIL reset_all_ones: got %b want 0", all_ones); else pass_cnt++;
      total_cnt++; if (all_zeros !== 1'b0) $display("FAIL reset_all_zeros: got %b want 0", all_zeros); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt); else pass_cnt++;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      drive(32'h0000_00FF, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_out_valid: got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (binary !== 6'd8) $display("FAIL basic_binary: got %0d want 8", binary); else pass_cnt++;
      total_cnt++; if (bubble !== 1'b0) $display("FAIL basic_bubble: got %b want 0", bubble); else pass_cnt++;
      total_cnt++; if ({all_ones, all_zeros} !== 2'b00) $display("FAIL basic_flags: got %b want 00", {all_ones, all_zeros}); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_pulse: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (binary !== 6'd8) $display("FAIL basic_hold: got %0d want 8", binary); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL basic_cnt: got %0d want %0d", bubble_cnt, exp_cnt); else pass_cnt++;
   endtask

   task automatic test_extremes();
      send(32'hFFFF_FFFF, 1'b0);
      total_cnt++; if (binary !== 6'd32) $display("FAIL ones_last_binary: got %0d want 32", binary); else pass_cnt++;
      total_cnt++; if ({all_ones, all_zeros, bubble} !== 3'b100) $display("FAIL ones_last_flags: got %b want 100", {all_ones, all_zeros, bubble}); else pass_cnt++;
      send(32'hFFFF_FFFF, 1'b1);
      total_cnt++; if (binary !== 6'd32) $display("FAIL ones_pop_binary: got %0d want 32", binary); else pass_cnt++;
      total_cnt++; if (all_ones !== 1'b1) $display("FAIL ones_pop_all_ones: got %b want 1", all_ones); else pass_cnt++;
      send(32'h0000_0000, 1'b0);
      total_cnt++; if (binary !== 6'd0) $display("FAIL zeros_last_binary: got %0d want 0", binary); else pass_cnt++;
      total_cnt++; if ({all_ones, all_zeros, bubble} !== 3'b010) $display("FAIL zeros_last_flags: got %b want 010", {all_ones, all_zeros, bubble}); else pass_cnt++;
      send(32'h0000_0000, 1'b1);
      total_cnt++; if ({binary, all_zeros} !== {6'd0, 1'b1}) $display("FAIL zeros_pop: got %0d/%b want 0/1", binary, all_zeros); else pass_cnt++;
   endtask

   task automatic test_bubble();
      send(32'h0000_00F7, 1'b0);
      total_cnt++; if (binary !== EXP_F7_M0) $display("FAIL bub_last_binary: got %0d want %0d", binary, EXP_F7_M0); else pass_cnt++;
      total_cnt++; if (bubble !== EXP_F7_BUB) $display("FAIL bub_last_flag: got %b want %b", bubble, EXP_F7_BUB); else pass_cnt++;
      step();
      exp_cnt = exp_cnt + {15'd0, EXP_F7_BUB};
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL bub_last_cnt: got %0d want %0d", bubble_cnt, exp_cnt); else pass_cnt++;
      send(32'h0000_00F7, 1'b1);
      total_cnt++; if (binary !== EXP_F7_M1) $display("FAIL bub_pop_binary: got %0d want %0d", binary, EXP_F7_M1); else pass_cnt++;
      total_cnt++; if (bubble !== EXP_F7_BUB) $display("FAIL bub_pop_flag: got %b want %b", bubble, EXP_F7_BUB); else pass_cnt++;
      step();
      exp_cnt = exp_cnt + {15'd0, EXP_F7_BUB};
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL bub_pop_cnt: got %0d want %0d", bubble_cnt, exp_cnt); else pass_cnt++;
   endtask

   // 0xF3 keeps a two-tap hole that survives the majority filter: pop 6, last 8.
   task automatic test_mode_switch();
      drive(32'h0000_00F3, 1'b1, 1'b0);
      step();
      drive(32'h0000_00F3, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      total_cnt++; if ({out_valid, binary, bubble} !== {1'b1, 6'd8, 1'b1}) $display("FAIL mode_first: got %b/%0d/%b want 1/8/1", out_valid, binary, bubble); else pass_cnt++;
      step();
      total_cnt++; if ({out_valid, binary, bubble} !== {1'b1, 6'd6, 1'b1}) $display("FAIL mode_second: got %b/%0d/%b want 1/6/1", out_valid, binary, bubble); else pass_cnt++;
      step();
      exp_cnt = exp_cnt + 16'd2;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mode_valid_end: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL mode_cnt: got %0d want %0d", bubble_cnt, exp_cnt); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] code;
      for (int cyc = 0; cyc < 13; cyc++) begin
         code = (32'd1 << cyc) - 32'd1;
         drive(code, (cyc < 10) ? 1'b1 : 1'b0, 1'b0);
         step();
         if (cyc >= 2 && cyc <= 11) begin
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", cyc, out_valid); else pass_cnt++;
            total_cnt++; if (binary !== 6'(cyc - 2)) $display("FAIL b2b_binary[%0d]: got %0d want %0d", cyc, binary, cyc - 2); else pass_cnt++;
         end else begin
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_idle[%0d]: got %b want 0", cyc, out_valid); else pass_cnt++;
         end
      end
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL b2b_cnt: got %0d want %0d", bubble_cnt, exp_cnt); else pass_cnt++;
   endtask

   task automatic test_rst_mid();
      logic [31:0] code;
      for (int cyc = 0; cyc < 5; cyc++) begin
         code = (32'd1 << (cyc + 1)) - 32'd1;
         drive(code, 1'b1, 1'b0);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      exp_cnt = 16'd0;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (bubble_cnt !== exp_cnt) $display("FAIL rst_mid_cnt: got %0d want 0", bubble_cnt); else pass_cnt++;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_flush[%0d]: got %b want 0", k, out_valid); else pass_cnt++;
      end
      drive(32'h0000_0007, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_lat1: got %b want 0", out_valid); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_lat2: got %b want 0", out_valid); else pass_cnt++;
      step();
      total_cnt++; if ({out_valid, binary} !== {1'b1, 6'd3}) $display("FAIL rst_mid_result: got %b/%0d want 1/3", out_valid, binary); else pass_cnt++;
      step();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 65540; i++) begin
         drive(32'h0000_00F3, 1'b1, 1'b0);
         step();
      end
      in_valid = 1'b0;
      step(); step(); step(); step();
      total_cnt++; if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", bubble_cnt); else pass_cnt++;
      send(32'h0000_00F3, 1'b0);
      total_cnt++; if (bubble !== 1'b1) $display("FAIL sat_bubble: got %b want 1", bubble); else pass_cnt++;
      step();
      total_cnt++; if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", bubble_cnt); else pass_cnt++;
      send(32'h0000_00F3, 1'b0);
      total_cnt++; if ({out_valid, bubble} !== 2'b11) $display("FAIL clr_setup: got %b want 11", {out_valid, bubble}); else pass_cnt++;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      total_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL clr_wins: got %h want 0", bubble_cnt); else pass_cnt++;
      step();
      total_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL clr_stays: got %h want 0", bubble_cnt); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_bubble();
      test_mode_switch();
      test_back_to_back();
      test_rst_mid();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
